// File: rtl/alarm_timer.sv
// -----------------------------------------------------------------------------
// alarm_timer
//
// Purpose:
//   Seconds-resolution countdown used by the alarm FSM. A start request loads
//   an interval of 1..15 seconds and counts it down once per second. A one-cycle
//   expired pulse is raised when the countdown completes. Loading zero expires
//   at once. An abort cancels the countdown without raising expired.
//
// Ports:
//   clock          in   system clock; all state changes on its rising edge
//   reset          in   asynchronous active-high reset
//   start_timer    in   load-and-start request (also restarts a running count)
//   abort          in   cancel a running countdown (highest priority)
//   value[3:0]     in   interval in seconds, sampled only on a start edge
//   expired        out  registered one-cycle pulse at end of countdown
//   busy           out  high while a countdown is running
//   remaining[3:0] out  seconds left in the current countdown
//   one_hz_enable  out  registered one-cycle pulse on each 1 s tick while running
//
// Parameters:
//   CYCLES_PER_SEC clock cycles per 1 s tick (must be >= 2)
// -----------------------------------------------------------------------------
module alarm_timer #(
    parameter int CYCLES_PER_SEC = 100000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_timer,
    input  logic       abort,
    input  logic [3:0] value,
    output logic       expired,
    output logic       busy,
    output logic [3:0] remaining,
    output logic       one_hz_enable
);

    localparam int PW = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam logic [PW-1:0] LAST_COUNT = PW'(CYCLES_PER_SEC - 1);

    typedef enum logic {
        S_IDLE,
        S_RUNNING
    } state_t;

    state_t        state;
    logic [PW-1:0] prescaler;
    logic          tick;

    // A tick marks the last cycle of each running second. The prescaler is
    // zeroed on the start edge, so the first tick lands exactly
    // CYCLES_PER_SEC cycles after the start edge.
    assign tick = (state == S_RUNNING) && (prescaler == LAST_COUNT);

    assign busy = (state == S_RUNNING);

    // Single state register for the whole timer. Abort beats start, and start
    // beats tick. So a restart on the final tick cycle replaces the old count
    // before it can expire. The expired and one_hz_enable outputs default low
    // every cycle, so each is a one-cycle pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            prescaler     <= '0;
            remaining     <= 4'd0;
            expired       <= 1'b0;
            one_hz_enable <= 1'b0;
        end else begin
            expired       <= 1'b0;
            one_hz_enable <= 1'b0;

            if (abort) begin
                state     <= S_IDLE;
                remaining <= 4'd0;
                prescaler <= '0;
            end else if (start_timer) begin
                prescaler <= '0;
                if (value != 4'd0) begin
                    state     <= S_RUNNING;
                    remaining <= value;
                end else begin
                    // A zero-length interval is already over: stay idle and
                    // signal completion straight away.
                    state     <= S_IDLE;
                    remaining <= 4'd0;
                    expired   <= 1'b1;
                end
            end else if (tick) begin
                prescaler     <= '0;
                one_hz_enable <= 1'b1;
                if (remaining > 4'd1) begin
                    remaining <= remaining - 4'd1;
                end else begin
                    remaining <= 4'd0;
                    state     <= S_IDLE;
                    expired   <= 1'b1;
                end
            end else if (state == S_RUNNING) begin
                prescaler <= prescaler + PW'(1);
            end else begin
                prescaler <= '0;
            end
        end
    end

endmodule
